// File: rtl/q_argmax_seq_if.sv
// Row-in / argmax-out handshake bundle for q_argmax_seq.
// The slave modport is the argmax unit; the master modport is its driver.
interface q_argmax_seq_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ACTIONS       = 4,
   parameter int ACTIONS_WIDTH = (ACTIONS > 2) ? $clog2(ACTIONS) : 1
);
   logic                          i_valid;
   logic                          o_ready;
   logic [DATA_WIDTH*ACTIONS-1:0] i_data;
   logic                          i_clear;
   logic                          o_valid;
   logic                          i_ready;
   logic [DATA_WIDTH-1:0]         o_max_value;
   logic [ACTIONS_WIDTH-1:0]      o_max_action;

   modport slave (
      input  i_valid, i_data, i_clear, i_ready,
      output o_ready, o_valid, o_max_value, o_max_action
   );

   modport master (
      output i_valid, i_data, i_clear, i_ready,
      input  o_ready, o_valid, o_max_value, o_max_action
   );
endinterface

// File: rtl/q_argmax_seq.sv
// Sequential argmax over one Q-row, LANES entries per clock, lowest index wins ties.
// Define Q_ARGMAX_SIGNED_EN to compare Q-values as two's-complement; otherwise unsigned.
module q_argmax_seq #(
   parameter int DATA_WIDTH    = 32,
   parameter int ACTIONS       = 4,
   parameter int LANES         = 1,
   parameter int ACTIONS_WIDTH = (ACTIONS > 2) ? $clog2(ACTIONS) : 1
) (
   input logic           i_clk,
   input logic           i_rst_n,
   q_argmax_seq_if.slave bus
);

   localparam int BEATS      = ACTIONS / LANES;
   localparam int BEAT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                   state_q;
   state_t                   state_d;
   logic                     armed_q;
   logic [BEAT_WIDTH-1:0]    beat_q;
   logic [DATA_WIDTH-1:0]    row_q [ACTIONS];
   logic [DATA_WIDTH-1:0]    max_value_q;
   logic [ACTIONS_WIDTH-1:0] max_action_q;
   logic [DATA_WIDTH-1:0]    beat_value;
   logic [ACTIONS_WIDTH-1:0] beat_action;
   logic [ACTIONS_WIDTH-1:0] lane_idx;
   logic [DATA_WIDTH-1:0]    lane_value;
   logic                     ready;
   logic                     accept;

   function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
`ifdef Q_ARGMAX_SIGNED_EN
      return $signed(a) > $signed(b);
`else
      return a > b;
`endif
   endfunction

   // A clear in the same cycle as a valid row wins: the row is not taken.
   assign accept = bus.i_valid && ready && !bus.i_clear;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= 1'b1;
      end
   end

   // NOTE: every signal written in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)              state_d = SCAN;
         SCAN:    if (beat_q == LAST_BEAT) state_d = DONE;
         DONE:    if (bus.i_ready)         state_d = IDLE;
         default:                          state_d = IDLE;
      endcase
      if (bus.i_clear) begin
         state_d = IDLE;
      end
   end

   // armed_q holds o_ready low until the first edge after reset is released.
   always_comb begin
      ready           = armed_q && (state_q == IDLE);
      bus.o_ready     = ready;
      bus.o_valid     = (state_q == DONE);
      bus.o_max_value  = max_value_q;
      bus.o_max_action = max_action_q;
   end

   // ------------------------------------------------------- lane reduction
   // NOTE: blocking assignments here build an ordered chain, lane 0 first, so an equal later lane never displaces an earlier one.
   always_comb begin
      lane_idx   = '0;
      lane_value = '0;
      if (beat_q == '0) begin
         beat_value  = row_q[0];
         beat_action = '0;
      end else begin
         beat_value  = max_value_q;
         beat_action = max_action_q;
      end
      for (int l = 0; l < LANES; l++) begin
         lane_idx   = ACTIONS_WIDTH'(int'(beat_q) * LANES + l);
         lane_value = row_q[lane_idx];
         if (greater(lane_value, beat_value)) begin
            beat_value  = lane_value;
            beat_action = lane_idx;
         end
      end
   end

   // ------------------------------------------------------------ datapath
   // NOTE: the row buffer is deliberately not reset; it is only read after an accept has overwritten every entry.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         for (int k = 0; k < ACTIONS; k++) begin
            row_q[k] <= bus.i_data[DATA_WIDTH*(ACTIONS-1-k) +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         beat_q       <= '0;
         max_value_q  <= '0;
         max_action_q <= '0;
      end else if (accept) begin
         beat_q <= '0;
      end else if (state_q == SCAN && !bus.i_clear) begin
         beat_q       <= (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_WIDTH'(1);
         max_value_q  <= beat_value;
         max_action_q <= beat_action;
      end
   end

endmodule

// File: tb/tb_q_argmax_seq.sv
// Self-checking bench for q_argmax_seq: a 4x1-lane instance and an 8x4-lane instance,
// directed vectors plus randomized rows checked against an argmax reference model.
module tb_q_argmax_seq;

   localparam int DW = 32;
   localparam int NA = 4;
   localparam int NB = 8;
   localparam int LB = 4;

   typedef struct packed {
      logic [0:NA-1][DW-1:0] row;
      logic [DW-1:0]         exp_v;
      logic [1:0]            exp_a;
      logic [7:0]            stall;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   q_argmax_seq_if #(.DATA_WIDTH(DW), .ACTIONS(NA)) bus_a ();
   q_argmax_seq_if #(.DATA_WIDTH(DW), .ACTIONS(NB)) bus_b ();

   q_argmax_seq #(.DATA_WIDTH(DW), .ACTIONS(NA), .LANES(1)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a.slave)
   );
   q_argmax_seq #(.DATA_WIDTH(DW), .ACTIONS(NB), .LANES(LB)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b.slave)
   );

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit q_gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef Q_ARGMAX_SIGNED_EN
      return $signed(a) > $signed(b);
`else
      return a > b;
`endif
   endfunction

   // Reference: find the maximum value, then the first action that holds it.
   function automatic void ref_argmax(input logic [DW-1:0] row[$], output logic [DW-1:0] best_v,
                                      output int best_a);
      best_v = row[0];
      foreach (row[k]) if (q_gt(row[k], best_v)) best_v = row[k];
      best_a = -1;
      foreach (row[k]) if (best_a < 0 && row[k] == best_v) best_a = k;
   endfunction

   task automatic run_a(input logic [DW-1:0] row[$], input logic [DW-1:0] exp_v, input int exp_a,
                        input int stall, input string tag);
      int            waited;
      logic [DW-1:0] hold_v;
      logic [1:0]    hold_a;
      waited = 0;
      while (!bus_a.o_ready && waited < 20) begin
         step();
         waited++;
      end
      check({tag, " ready_before_accept"}, 64'(bus_a.o_ready), 64'd1);
      for (int k = 0; k < NA; k++) bus_a.i_data[DW*(NA-1-k) +: DW] = row[k];
      bus_a.i_valid = 1'b1;
      step();
      bus_a.i_valid = 1'b0;
      bus_a.i_data  = {$urandom, $urandom, $urandom, $urandom};
      check({tag, " ready_low_after_accept"}, 64'(bus_a.o_ready), 64'd0);
      waited = 0;
      while (!bus_a.o_valid && waited < 50) begin
         step();
         waited++;
         bus_a.i_data = {$urandom, $urandom, $urandom, $urandom};
      end
      check({tag, " latency"}, 64'(waited), 64'(NA));
      check({tag, " max_value"}, 64'(bus_a.o_max_value), 64'(exp_v));
      check({tag, " max_action"}, 64'(bus_a.o_max_action), 64'(exp_a));
      check({tag, " ready_low_in_done"}, 64'(bus_a.o_ready), 64'd0);
      hold_v = bus_a.o_max_value;
      hold_a = bus_a.o_max_action;
      for (int c = 0; c < stall; c++) begin
         step();
         check({tag, " stall_hold"},
               64'({bus_a.o_valid, bus_a.o_ready, bus_a.o_max_action, bus_a.o_max_value}),
               64'({1'b1, 1'b0, hold_a, hold_v}));
      end
      bus_a.i_ready = 1'b1;
      step();
      bus_a.i_ready = 1'b0;
      check({tag, " valid_low_after_handshake"}, 64'(bus_a.o_valid), 64'd0);
      check({tag, " ready_high_after_handshake"}, 64'(bus_a.o_ready), 64'd1);
   endtask

   task automatic run_b(input logic [DW-1:0] row[$], input logic [DW-1:0] exp_v, input int exp_a,
                        input string tag);
      int waited;
      waited = 0;
      while (!bus_b.o_ready && waited < 20) begin
         step();
         waited++;
      end
      check({tag, " ready_before_accept"}, 64'(bus_b.o_ready), 64'd1);
      for (int k = 0; k < NB; k++) bus_b.i_data[DW*(NB-1-k) +: DW] = row[k];
      bus_b.i_valid = 1'b1;
      step();
      bus_b.i_valid = 1'b0;
      bus_b.i_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      waited = 0;
      while (!bus_b.o_valid && waited < 50) begin
         step();
         waited++;
      end
      check({tag, " latency"}, 64'(waited), 64'(NB / LB));
      check({tag, " max_value"}, 64'(bus_b.o_max_value), 64'(exp_v));
      check({tag, " max_action"}, 64'(bus_b.o_max_action), 64'(exp_a));
      bus_b.i_ready = 1'b1;
      step();
      bus_b.i_ready = 1'b0;
      check({tag, " ready_high_after_handshake"}, 64'(bus_b.o_ready), 64'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t          vecs[5];
      logic [DW-1:0] q[$];
      logic [DW-1:0] exp_v;
      logic [DW-1:0] v;
      int            exp_a;
      int            mode;
      bit            saw_valid;

      vecs[0] = '{row: {32'd3, 32'd9, 32'd2, 32'd7}, exp_v: 32'd9, exp_a: 2'd1, stall: 8'd0};
      vecs[1] = '{row: {32'd5, 32'd3, 32'd5, 32'd5}, exp_v: 32'd5, exp_a: 2'd0, stall: 8'd1};
      vecs[2] = '{row: {32'd1, 32'd8, 32'd8, 32'd0}, exp_v: 32'd8, exp_a: 2'd1, stall: 8'd0};
`ifdef Q_ARGMAX_SIGNED_EN
      vecs[3] = '{row: {32'h5, 32'hFFFF_FFF0, 32'h3, 32'h5}, exp_v: 32'h5, exp_a: 2'd0, stall: 8'd2};
`else
      vecs[3] = '{row: {32'h5, 32'hFFFF_FFF0, 32'h3, 32'h5}, exp_v: 32'hFFFF_FFF0, exp_a: 2'd1, stall: 8'd2};
`endif
      vecs[4] = '{row: {32'd7, 32'd7, 32'd100, 32'd100}, exp_v: 32'd100, exp_a: 2'd2, stall: 8'd10};

      bus_a.i_valid = 1'b0; bus_a.i_data = '0; bus_a.i_clear = 1'b0; bus_a.i_ready = 1'b0;
      bus_b.i_valid = 1'b0; bus_b.i_data = '0; bus_b.i_clear = 1'b0; bus_b.i_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) step();

      // Reset state
      check("reset a_outputs",
            64'({bus_a.o_ready, bus_a.o_valid, bus_a.o_max_action, bus_a.o_max_value}), 64'd0);
      check("reset b_outputs",
            64'({bus_b.o_ready, bus_b.o_valid, bus_b.o_max_action, bus_b.o_max_value}), 64'd0);
      rst_n = 1'b1;
      #2;
      check("ready_low_before_first_edge", 64'(bus_a.o_ready), 64'd0);
      step();
      check("ready_high_after_first_edge a", 64'(bus_a.o_ready), 64'd1);
      check("ready_high_after_first_edge b", 64'(bus_b.o_ready), 64'd1);

      // Directed vector table
      for (int i = 0; i < 5; i++) begin
         q = {};
         for (int k = 0; k < NA; k++) q.push_back(vecs[i].row[k]);
         run_a(q, vecs[i].exp_v, int'(vecs[i].exp_a), int'(vecs[i].stall), $sformatf("vec%0d", i));
      end

      // Clear during SCAN beat 2, then a fresh row
      bus_a.i_data  = {32'd9, 32'd9, 32'd9, 32'd9};
      bus_a.i_valid = 1'b1;
      step();
      bus_a.i_valid = 1'b0;
      step();
      step();
      bus_a.i_clear = 1'b1;
      step();
      bus_a.i_clear = 1'b0;
      check("clear_scan valid_low", 64'(bus_a.o_valid), 64'd0);
      check("clear_scan ready_high", 64'(bus_a.o_ready), 64'd1);
      saw_valid = 1'b0;
      repeat (6) begin
         step();
         saw_valid |= bus_a.o_valid;
      end
      check("clear_scan no_stale_valid", 64'(saw_valid), 64'd0);
      q = {32'd0, 32'd0, 32'd0, 32'd4};
      run_a(q, 32'd4, 3, 0, "after_clear");

      // Clear in the same cycle as an accept: row is not taken
      bus_a.i_data  = {32'd1, 32'd2, 32'd3, 32'd4};
      bus_a.i_valid = 1'b1;
      bus_a.i_clear = 1'b1;
      step();
      bus_a.i_valid = 1'b0;
      bus_a.i_clear = 1'b0;
      check("clear_accept ready_still_high", 64'(bus_a.o_ready), 64'd1);
      saw_valid = 1'b0;
      repeat (8) begin
         step();
         saw_valid |= bus_a.o_valid;
      end
      check("clear_accept no_result", 64'(saw_valid), 64'd0);

      // Clear while in DONE: valid drops, result registers keep their value
      bus_a.i_data  = {32'd2, 32'd6, 32'd6, 32'd1};
      bus_a.i_valid = 1'b1;
      step();
      bus_a.i_valid = 1'b0;
      repeat (NA) step();
      check("clear_done valid_before", 64'(bus_a.o_valid), 64'd1);
      bus_a.i_clear = 1'b1;
      step();
      bus_a.i_clear = 1'b0;
      check("clear_done valid_low", 64'(bus_a.o_valid), 64'd0);
      check("clear_done ready_high", 64'(bus_a.o_ready), 64'd1);
      check("clear_done result_kept", 64'({bus_a.o_max_action, bus_a.o_max_value}), 64'({2'd1, 32'd6}));

      // Randomized rows on the single-lane instance
      for (int it = 0; it < 30; it++) begin
         q    = {};
         mode = int'($urandom_range(0, 2));
         for (int k = 0; k < NA; k++) begin
            case (mode)
               0:       v = $urandom;
               1:       v = DW'($urandom_range(0, 3));
               default: v = {($urandom_range(0, 1) == 1) ? 28'hFFF_FFFF : 28'h0, 4'($urandom_range(0, 15))};
            endcase
            q.push_back(v);
         end
         ref_argmax(q, exp_v, exp_a);
         run_a(q, exp_v, exp_a, int'($urandom_range(0, 3)), $sformatf("rand_a%0d", it));
      end

      // Four-lane instance: directed rows
      q = {32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80};
      run_b(q, 32'd80, 7, "lanes4_ramp");
      q = {32'd5, 32'd9, 32'd1, 32'd2, 32'd9, 32'd9, 32'd0, 32'd3};
      run_b(q, 32'd9, 1, "lanes4_tie_across_beats");
      q = {32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd6, 32'd6, 32'd2};
      run_b(q, 32'd6, 5, "lanes4_tie_in_beat");

      for (int it = 0; it < 15; it++) begin
         q    = {};
         mode = int'($urandom_range(0, 1));
         for (int k = 0; k < NB; k++) begin
            v = (mode == 0) ? $urandom : DW'($urandom_range(0, 3));
            q.push_back(v);
         end
         ref_argmax(q, exp_v, exp_a);
         run_b(q, exp_v, exp_a, $sformatf("rand_b%0d", it));
      end

      // Asynchronous reset mid-SCAN on the four-lane instance
      bus_b.i_data  = {32'd10, 32'd20, 32'd30, 32'd40, 32'd1, 32'd2, 32'd3, 32'd4};
      bus_b.i_valid = 1'b1;
      step();
      bus_b.i_valid = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      check("async_reset b_outputs_zero",
            64'({bus_b.o_ready, bus_b.o_valid, bus_b.o_max_action, bus_b.o_max_value}), 64'd0);
      step();
      rst_n = 1'b1;
      step();
      check("after_reset b_ready", 64'(bus_b.o_ready), 64'd1);
      saw_valid = 1'b0;
      repeat (5) begin
         step();
         saw_valid |= bus_b.o_valid;
      end
      check("after_reset b_no_result", 64'(saw_valid), 64'd0);
      q = {32'd3, 32'd1, 32'd4, 32'd1, 32'd5, 32'd9, 32'd2, 32'd6};
      run_b(q, 32'd9, 5, "after_reset_b");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/q_argmax_seq.md
# q_argmax_seq

Sequential, parametrised argmax unit for the Q-learning datapath. It accepts one Q-row (ACTIONS values of DATA_WIDTH bits), scans it LANES entries per clock, and returns the maximum value and the index of the action holding it. A valid/ready handshake sits on each side. It supersedes the combinational max-to-index lookup in the action-selection path: it computes the maximum itself, breaks ties deterministically, and scales to any action count.

## Interface
- DATA_WIDTH, 32: width of one Q-value.
- ACTIONS, 4: number of actions per row; ACTIONS ≥ 2 and ACTIONS % LANES == 0.
- LANES, 1: entries compared per clock; legal values are 1, 2, 4, …, ACTIONS.
- ACTIONS_WIDTH, $clog2(ACTIONS): index width, minimum 1.

Ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_valid  in  1  input row valid.
- o_ready  out  1  block can accept a row.
- i_data  in  DATA_WIDTH*ACTIONS  Q-row; action k at bits [DATA_WIDTH*(ACTIONS-k)-1 : DATA_WIDTH*(ACTIONS-k-1)], so action 0 is the MSB slice.
- i_clear  in  1  synchronous abort; returns to IDLE.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_max_value  out  DATA_WIDTH  maximum Q-value.
- o_max_action  out  ACTIONS_WIDTH  index of the maximum.

## Operation
- FSM states are IDLE, SCAN and DONE. o_ready is 1 only in IDLE. o_valid is 1 only in DONE.
- IDLE: on i_valid && o_ready, register i_data into the row buffer, clear the beat counter to 0, and go to SCAN.
- SCAN, beat b (0 … ACTIONS/LANES-1):
  - Compare entries b*LANES … b*LANES+LANES-1 in ascending index order against the running max.
  - Beat 0 seeds the running max with entry 0 before comparing the rest.
  - An entry replaces the running max only if it is strictly greater, so ties resolve to the lowest index.
  - The lane-internal reduction follows the same rule.
  - On the last beat, go to DONE.
- DONE: o_max_value and o_max_action are held stable. On i_ready, go to IDLE.
- i_clear has priority over all transitions. From any state it goes to IDLE next edge and drops o_valid. Buffered data is discarded. Output data registers are not cleared.
- Row buffer and result registers change only at the accept edge (buffer) or during SCAN (results). i_data changes outside an accept have no effect.
- Comparison mode is set by the macro (see Configuration). Everything else is mode-independent.

## Timing
- Reset (i_rst_n low, asynchronous):
  - state = IDLE.
  - o_ready = 0; it rises at the first i_clk edge after reset deasserts.
  - o_valid = 0, o_max_value = 0, o_max_action = 0, beat counter = 0.
- Latency: with the accept at edge E, o_valid is high after edge E + ACTIONS/LANES.
  - ACTIONS=4, LANES=1: 4 cycles.
  - LANES=ACTIONS: 1 cycle.
- Throughput: one row per ACTIONS/LANES + 2 cycles when i_ready is tied high (accept, scan beats, DONE, IDLE). Input and output phases do not overlap.
- Backpressure: o_valid may stay high indefinitely; outputs are stable while i_ready is low.
- o_ready falls the edge after the accept. It rises the edge after the output handshake or after i_clear.
- i_clear asserted in the same cycle as an accept: the clear wins and the row is not taken.
- Asynchronous reset mid-SCAN or mid-DONE aborts immediately; no result is produced.

## Configuration
- `Q_ARGMAX_SIGNED_EN` defined: Q-values are compared as two's-complement signed. This matches the fixed-point Q-table.
- Not defined: Q-values are compared as unsigned magnitudes.
- No port or latency difference between the two modes.

## Test plan
- Reset, default params, row {A0..A3} = {3, 9, 2, 7}: o_valid rises 4 cycles after the accept; o_max_value=9, o_max_action=1.
- Tie case, row {5, 3, 5, 5}: o_max_action=0, o_max_value=5. Row {1, 8, 8, 0}: o_max_action=1.
- Sign mode, row {0x00000005, 0xFFFFFFF0, 0x00000003, 0x00000005}: with `Q_ARGMAX_SIGNED_EN`, result 5 at action 0; without it, result 0xFFFFFFF0 at action 1.
- Backpressure: hold i_ready=0 for 10 cycles in DONE. Outputs stay stable and o_ready stays 0. i_ready=1 gives o_ready=1 on the next cycle.
- i_clear during SCAN beat 2, then a new row {0,0,0,4}: no stale o_valid; the new result is 4 at action 3.
- LANES=4, ACTIONS=8, row 10,20,…,80 with the max at action 7: latency 2 cycles; o_max_action=7. Async reset mid-SCAN drops all outputs to 0 immediately.
